fp_add_arbiter: RTL
===================

# fp_add_arbiter

Round-robin scheduler that shares the team's single combinational 32-bit floating-point adder among `NUM_REQ` requesters. It accepts one operation at a time over per-requester valid/ready handshakes and latches the operands. It then drives them onto the adder port, registers the adder output, and returns the result tagged with the requester ID. It sits between the ALU issue logic and the FP adder datapath, which is connected externally through the `fpa_*` ports.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `N`, 32: operand width (IEEE-754 single).
- `IDW`, derived: max(1, clog2(NUM_REQ)), requester ID width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset: asynchronous, active-low. Single clock domain.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ready`  out  NUM_REQ  one-hot grant/accept, combinational.
- `req_a`  in  NUM_REQ*N  operand A; requester i occupies bits [i*N +: N].
- `req_b`  in  NUM_REQ*N  operand B, packed the same way.
- `req_sub`  in  NUM_REQ  1 = compute A-B (flip sign bit of B).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  result consumer accepts.
- `rsp_data`  out  N  registered adder result.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.
- `fpa_in1`  out  N  to adder `in1`, registered.
- `fpa_in2`  out  N  to adder `in2`, registered.
- `fpa_result`  in  N  from adder `result`, combinational in the same cycle.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and HOLD. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` is high, the arbiter selects grant g by round-robin.
  - The search starts at `last_grant+1` (mod NUM_REQ) and picks the first requester with `req_valid` high.
  - `req_ready[g]` = 1 combinationally; all other `req_ready` bits = 0.
  - On that clock edge: `fpa_in1` <= `req_a[g]`, `fpa_in2` <= `req_b[g]` with bit N-1 XOR `req_sub[g]`, `cur_id` <= g, `last_grant` <= g. Next state is EXEC.
  - With no valid request, all `req_ready` bits are 0 and the FSM stays in IDLE.
- **EXEC:**
  - `rsp_data` <= `fpa_result`, `rsp_id` <= `cur_id`, `rsp_valid` <= 1. Next state is HOLD.
- **HOLD:**
  - `rsp_valid`, `rsp_data` and `rsp_id` hold stable until `rsp_ready` = 1.
  - On the edge where `rsp_valid` and `rsp_ready` are both high, `rsp_valid` <= 0 and the FSM goes to IDLE.
- `req_ready` is 0 in EXEC and HOLD. At most one operation is in flight.
- Requesters hold `req_valid`, `req_a`, `req_b` and `req_sub` stable until accepted.
- `req_valid` must not depend combinationally on `req_ready`.
- `last_grant` resets to NUM_REQ-1, so requester 0 has highest priority after reset. It updates only on a grant.
- A requester that deasserts `req_valid` before being granted is skipped with no penalty.
- The block is pass-through for special values. NaN, infinity and zero produced by the adder are returned unmodified; the block does not inspect data.
- `fpa_in1`/`fpa_in2` keep their last values after an operation completes. They change only on a grant.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert use): `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `fpa_in1` = 0, `fpa_in2` = 0, `busy` = 0, `req_ready` = 0, state = IDLE, `last_grant` = NUM_REQ-1.
- Accept at edge T (`req_valid[g]` and `req_ready[g]` both high). EXEC occupies cycle T..T+1. `rsp_valid` = 1 from edge T+1, i.e. visible in the cycle after EXEC. Latency from accept to `rsp_valid` is 2 edges.
- Response handshake at edge H: the earliest next accept is edge H+1, and `req_ready` is first visible in the cycle after H. Minimum issue interval is 3 cycles.
- Reset asserted in EXEC or HOLD: the in-flight operation is dropped and no response is produced. Outputs go to reset values immediately.
- `rsp_ready` high while `rsp_valid` is low has no effect.

## Test plan
- **Single op:** requester 2 sends A=0x3F800000, B=0x40000000, sub=0. Required: `req_ready` = 0b0100 for one cycle, then 2 cycles later `rsp_valid`=1, `rsp_data`=0x40400000, `rsp_id`=2.
- **Subtract:** requester 0 sends A=0x40400000, B=0x3F800000, sub=1. Required: `fpa_in2`=0xBF800000, `rsp_data`=0x40000000, `rsp_id`=0.
- **Contention:** all four `req_valid` held high from reset, `rsp_ready`=1. Required grant order is 0,1,2,3,0,…, with one accept every 3 cycles.
- **Fairness:** requesters 0 and 3 stay valid and 3 is granted first after a pointer preset. Required: the next grant is 0, then 3, alternating.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with other requests pending. Required: `rsp_data` and `rsp_id` are stable, `req_ready` is 0 throughout, and the next grant comes 1 cycle after the handshake.
- **Reset mid-op:** pulse `rst_n` low during EXEC. Required: `rsp_valid` never rises and all outputs are 0. After release, requester 0 wins against simultaneous requests from 0 and 1.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin scheduler sharing one external combinational FP adder
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int N = 32,
  parameter int IDW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic [N-1:0]         fpa_in1,
  output logic [N-1:0]         fpa_in2,
  input  logic [N-1:0]         fpa_result,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d, cur_id_q, cur_id_d, rsp_id_q, rsp_id_d;
  logic [IDW-1:0] gnt_id, idx;
  logic [N-1:0] fpa_in1_q, fpa_in1_d, fpa_in2_q, fpa_in2_d, rsp_data_q, rsp_data_d;
  logic rsp_valid_q, rsp_valid_d, found;
  logic [N-1:0] a_arr [NUM_REQ];
  logic [N-1:0] b_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*N +: N];
  end
  // first valid requester after the last grant, wrapping
  always_comb begin
    found = 1'b0;
    gnt_id = last_grant_q;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign req_ready = (rst_n && state_q == IDLE && found) ? NUM_REQ'(1) << gnt_id : '0;
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    cur_id_d = cur_id_q;
    fpa_in1_d = fpa_in1_q;
    fpa_in2_d = fpa_in2_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    if (state_q == IDLE && found) begin
      fpa_in1_d = a_arr[gnt_id];
      fpa_in2_d = b_arr[gnt_id] ^ {req_sub[gnt_id], {(N-1){1'b0}}};
      cur_id_d = gnt_id;
      last_grant_d = gnt_id;
      state_d = EXEC;
    end else if (state_q == EXEC) begin
      rsp_data_d = fpa_result;
      rsp_id_d = cur_id_q;
      rsp_valid_d = 1'b1;
      state_d = HOLD;
    end else if (state_q == HOLD && rsp_ready) begin
      rsp_valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      cur_id_q <= '0;
      fpa_in1_q <= '0;
      fpa_in2_q <= '0;
      rsp_data_q <= '0;
      rsp_id_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q <= cur_id_d;
      fpa_in1_q <= fpa_in1_d;
      fpa_in2_q <= fpa_in2_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign fpa_in1 = fpa_in1_q;
  assign fpa_in2 = fpa_in2_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy = state_q != IDLE;
endmodule
